audio_frame_sequencer: RTL

Sequences the per-channel output of the I2S audio receiver into stereo frames for the NPU feature path. It enforces left-then-right channel order and pairs the two samples into one frame. Frames are buffered in a small first-word-fall-through FIFO and handed downstream over a valid/ready handshake. Order faults, stalled right channels and buffer overflow are reported to the system controller.

---
 rtl/audio_frame_sequencer_if.sv | 23 ++
 rtl/audio_frame_sequencer.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/audio_frame_sequencer_if.sv
// rtl/audio_frame_sequencer_if.sv - stereo frame output stream (valid/ready) between sequencer and consumer
interface audio_frame_sequencer_if #(
  parameter int SAMPLE_W = 16
);
  logic [SAMPLE_W-1:0] frame_left;
  logic [SAMPLE_W-1:0] frame_right;
  logic                frame_valid;
  logic                frame_ready;

  modport master (
    output frame_left,
    output frame_right,
    output frame_valid,
    input  frame_ready
  );

  modport slave (
    input  frame_left,
    input  frame_right,
    input  frame_valid,
    output frame_ready
  );
endinterface

// File: rtl/audio_frame_sequencer.sv
// rtl/audio_frame_sequencer.sv - pairs I2S left/right samples into stereo frames buffered in a FWFT FIFO
// Optional right-channel watchdog enabled by defining AUDIO_SEQ_TIMEOUT_EN.
module audio_frame_sequencer #(
  parameter int SAMPLE_W    = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic                          enable,
  input  logic [SAMPLE_W-1:0]           in_sample,
  input  logic                          in_valid,
  input  logic                          in_channel,
  audio_frame_sequencer_if.master       frame,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          order_err,
  output logic                          timeout_err,
  output logic [7:0]                    drop_count,
  output logic                          busy
);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_L, WAIT_R} state_t;

  state_t              state;
  logic [SAMPLE_W-1:0] left_hold;
  logic [SAMPLE_W-1:0] mem_l [FIFO_DEPTH];
  logic [SAMPLE_W-1:0] mem_r [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic                push;
  logic                pop;
  logic                full;
  logic                accept;

  always_comb begin
    push   = enable && in_valid && in_channel && (state == WAIT_R);
    full   = (fifo_level == (PW+1)'(FIFO_DEPTH));
    pop    = frame.frame_valid && frame.frame_ready;
    accept = push && (!full || pop);
  end

  assign frame.frame_valid = (fifo_level != '0);
  assign frame.frame_left  = mem_l[rd_ptr];
  assign frame.frame_right = mem_r[rd_ptr];
  assign busy              = (state != IDLE);

`ifdef AUDIO_SEQ_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TW-1:0] to_cnt;
  logic          to_hit;
  assign to_hit = (to_cnt == TW'(TIMEOUT_CYC - 1));
`else
  assign timeout_err = 1'b0;
`endif

  // Dropping enable wins over any strobe in the same cycle and abandons the half-frame.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      left_hold <= '0;
      order_err <= 1'b0;
`ifdef AUDIO_SEQ_TIMEOUT_EN
      to_cnt      <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      order_err <= 1'b0;
`ifdef AUDIO_SEQ_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      if (!enable) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: state <= WAIT_L;
          WAIT_L: begin
            if (in_valid) begin
              if (!in_channel) begin
                left_hold <= in_sample;
                state     <= WAIT_R;
`ifdef AUDIO_SEQ_TIMEOUT_EN
                to_cnt    <= '0;
`endif
              end else begin
                order_err <= 1'b1;
              end
            end
          end
          WAIT_R: begin
            if (in_valid && in_channel) begin
              state <= WAIT_L;
            end else if (in_valid) begin
              order_err <= 1'b1;
              left_hold <= in_sample;
`ifdef AUDIO_SEQ_TIMEOUT_EN
              to_cnt    <= '0;
            end else if (to_hit) begin
              timeout_err <= 1'b1;
              state       <= WAIT_L;
            end else begin
              to_cnt <= to_cnt + 1'b1;
`endif
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // A full FIFO still accepts a push when the head is popped in the same cycle.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      drop_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_l[i] <= '0;
        mem_r[i] <= '0;
      end
    end else begin
      if (accept) begin
        mem_l[wr_ptr] <= left_hold;
        mem_r[wr_ptr] <= in_sample;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (accept && !pop) begin
        fifo_level <= fifo_level + 1'b1;
      end else if (!accept && pop) begin
        fifo_level <= fifo_level - 1'b1;
      end
      if (push && !accept && (drop_count != 8'hFF)) begin
        drop_count <= drop_count + 1'b1;
      end
    end
  end
endmodule
